// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter: requests, grants/acks and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       fifo_din;
    logic                    fifo_wr_en;
    logic                    fifo_full;
    logic                    busy;
    logic [OW-1:0]           owner;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_din, fifo_wr_en, busy, owner
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_din, fifo_wr_en, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting bursts of up to MAX_BURST words and stalling on FIFO full.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [OW-1:0]     sel_idx;
    logic              sel_found;
    logic              own_req;
    logic [DATA_W-1:0] own_data;
    logic              wr;
    int                idx;

    // First requester found scanning upward from rr_ptr with wrap-around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!sel_found && bus.req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req  = bus.req[i];
                own_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr             = (state_q == GRANT) && own_req && !bus.fifo_full;
    assign bus.fifo_wr_en = wr;
    assign bus.ack        = wr ? gnt_q : '0;
    assign bus.fifo_din   = (state_q == GRANT) ? own_data : '0;
    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d        = GRANT;
                    owner_d        = sel_idx;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                end
            end
            GRANT: begin
                if (wr) cnt_d = cnt_q + 1'b1;
                // Count-based release happens on the cycle the last word is written
                if (!own_req || (wr && cnt_q == CW'(MAX_BURST - 1))) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin order, short bursts,
// full stalls, async reset mid-burst and back-to-back bursts of one requester.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [15:0] wq[$];

    fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(16)) bus ();

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(16), .MAX_BURST(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [15:0] d);
        bus.req_data[i*16 +: 16] = d;
    endtask

    // n consecutive write cycles by requester own carrying word d
    task automatic burst(input int own, input int n, input logic [15:0] d);
        logic [3:0] oh;
        oh = 4'b0001 << own;
        for (int i = 0; i < n; i++) begin
            chk("gnt",   32'(bus.gnt), 32'(oh));
            chk("owner", 32'(bus.owner), 32'(own));
            chk("wr_en", 32'(bus.fifo_wr_en), 32'd1);
            chk("din",   32'(bus.fifo_din), 32'(d));
            chk("ack",   32'(bus.ack), 32'(oh));
            nxt();
        end
    endtask

    task automatic bubble(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    endtask

    // Write log plus invariants sampled with pre-edge values
    always @(posedge clk) begin
        if (bus.fifo_wr_en) wq.push_back(bus.fifo_din);
        chk("inv_full", 32'(bus.fifo_wr_en & bus.fifo_full), 32'd0);
        chk("inv_ack",  32'(|(bus.ack & ~bus.gnt)), 32'd0);
        chk("inv_gnt",  32'(bus.busy ? $onehot(bus.gnt) : (bus.gnt == 4'b0)), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int w;
        int nb[3];
        n_chk = 0;
        n_err = 0;
        reset         = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // 1: reset, then single requester full burst
        #2;
        chk("rst_gnt",   32'(bus.gnt), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        #4 reset = 1'b1;
        @(negedge clk); #1;
        bus.req = 4'b0001;
        set_data(0, 16'h0017);
        #1;
        chk("t1_idle_gnt", 32'(bus.gnt), 32'd0);
        chk("t1_idle_wr",  32'(bus.fifo_wr_en), 32'd0);
        chk("t1_idle_din", 32'(bus.fifo_din), 32'd0);
        nxt();
        chk("t1_busy", 32'(bus.busy), 32'd1);
        burst(0, 8, 16'h0017);
        bubble("t1_rel");
        chk("t1_count", 32'(wq.size()), 32'd8);

        // 2: all requesting; rr_ptr=1 after test 1 so order is 1,2,3,0,1
        for (int i = 0; i < 4; i++) set_data(i, 16'hA000 + 16'(i));
        bus.req = 4'b1111;
        wq.delete();
        order = '{1, 2, 3, 0, 1};
        nxt();
        for (int g = 0; g < 5; g++) begin
            burst(order[g], 8, 16'hA000 + 16'(order[g]));
            bubble("t2_gap");
            if (g == 4) bus.req = 4'b0000;
            nxt();
        end
        chk("t2_count", 32'(wq.size()), 32'd40);
        chk("t2_idle",  32'(bus.gnt), 32'd0);

        // 3: requester 2 stops after 3 words; requester 3 then granted
        wq.delete();
        set_data(2, 16'hC002);
        set_data(3, 16'hC003);
        bus.req = 4'b1100;
        nxt();
        burst(2, 3, 16'hC002);
        bus.req = 4'b1000;
        #1;
        chk("t3_rel_wr",   32'(bus.fifo_wr_en), 32'd0);
        chk("t3_rel_ack",  32'(bus.ack), 32'd0);
        chk("t3_rel_gnt",  32'(bus.gnt), 32'b0100);
        chk("t3_count",    32'(wq.size()), 32'd3);
        nxt();
        bubble("t3_gap");
        nxt();
        chk("t3_next_gnt", 32'(bus.gnt), 32'b1000);

        // 4: full stall after 4 words of requester 3
        wq.delete();
        burst(3, 4, 16'hC003);
        bus.fifo_full = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk("t4_stall_wr",   32'(bus.fifo_wr_en), 32'd0);
            chk("t4_stall_ack",  32'(bus.ack), 32'd0);
            chk("t4_stall_gnt",  32'(bus.gnt), 32'b1000);
            chk("t4_stall_busy", 32'(bus.busy), 32'd1);
            nxt();
        end
        bus.fifo_full = 1'b0;
        #1;
        burst(3, 4, 16'hC003);
        bubble("t4_rel");
        chk("t4_count", 32'(wq.size()), 32'd8);

        // 5: async reset at word 5 of a burst
        nxt();
        burst(3, 4, 16'hC003);
        chk("t5_w5_wr", 32'(bus.fifo_wr_en), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t5_ar_gnt",   32'(bus.gnt), 32'd0);
        chk("t5_ar_busy",  32'(bus.busy), 32'd0);
        chk("t5_ar_wr",    32'(bus.fifo_wr_en), 32'd0);
        chk("t5_ar_ack",   32'(bus.ack), 32'd0);
        chk("t5_ar_owner", 32'(bus.owner), 32'd0);
        chk("t5_ar_din",   32'(bus.fifo_din), 32'd0);
        bus.req = 4'b0010;
        nxt();
        chk("t5_held_gnt", 32'(bus.gnt), 32'd0);
        reset = 1'b1;
        nxt();
        chk("t5_gnt",   32'(bus.gnt), 32'b0010);
        chk("t5_owner", 32'(bus.owner), 32'd1);
        bus.req = 4'b0000;
        #1;
        chk("t5_drop_wr", 32'(bus.fifo_wr_en), 32'd0);
        nxt();
        bubble("t5_rel");
        chk("t5_owner_hold", 32'(bus.owner), 32'd1);

        // 6: requester 3 alone streams 20 words as bursts of 8, 8, 4
        wq.delete();
        w = 0;
        nb = '{8, 8, 4};
        set_data(3, 16'h0020);
        bus.req = 4'b1000;
        nxt();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < nb[b]; k++) begin
                chk("t6_gnt", 32'(bus.gnt), 32'b1000);
                chk("t6_ack", 32'(bus.ack), 32'b1000);
                chk("t6_din", 32'(bus.fifo_din), 32'(16'h0020 + 16'(w)));
                w++;
                nxt();
                if (w == 20) bus.req = 4'b0000;
                else set_data(3, 16'h0020 + 16'(w));
                #1;
            end
            if (b == 2) begin
                chk("t6_tail_wr",  32'(bus.fifo_wr_en), 32'd0);
                chk("t6_tail_gnt", 32'(bus.gnt), 32'b1000);
                nxt();
            end
            bubble("t6_gap");
            nxt();
        end
        chk("t6_count", 32'(wq.size()), 32'd20);
        for (int i = 0; i < 20 && i < wq.size(); i++)
            chk("t6_order", 32'(wq[i]), 32'(16'h0020 + 16'(i)));
        chk("t6_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
